keypad_operand_entry: RTL and testbench

Downstream consumer of the keypad scanner's 4-bit key code (4'hF = no key).
- Qualifies raw codes into single key events: one event per physical press, tolerant of the scanner's intermittent 4'hF gaps.
- Builds two decimal operands from digit keys, then computes their sum.
- Feeds the display/result stage with the current entry value and a one-cycle result strobe.

---
 rtl/keypad_pkg.sv | 23 ++
 rtl/key_event.sv | 64 ++++++
 rtl/keypad_operand_entry.sv | 189 ++++++++++++++++++
 tb/tb_keypad_operand_entry.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad operand entry block.
// Holds the special key codes, the entry FSM states and the key qualifier states.
// Build option: KEYPAD_SUB_EN enables subtraction via key B (see keypad_operand_entry).
package keypad_pkg;

  localparam logic [3:0] KEY_ADD  = 4'hA;
  localparam logic [3:0] KEY_SUB  = 4'hB;
  localparam logic [3:0] KEY_CLR  = 4'hD;
  localparam logic [3:0] KEY_EQ   = 4'hE;
  localparam logic [3:0] KEY_NONE = 4'hF;

  typedef enum logic [1:0] {
    S_A    = 2'd0,
    S_B    = 2'd1,
    S_DONE = 2'd2
  } entry_state_t;

  typedef enum logic {
    ARMED        = 1'b0,
    WAIT_RELEASE = 1'b1
  } qual_state_t;

endpackage

// File: rtl/key_event.sv
// Turns the raw scanner key code into one event per physical key press.
// Ports:
//   clk, reset  system clock, synchronous active-high reset
//   key_code    raw scanner code (4'hF = no key)
//   key_evt     one-cycle pulse, combinational, valid at the edge that applies the key
//   evt_code    key code belonging to key_evt
module key_event
  import keypad_pkg::*;
#(
  parameter int unsigned RELEASE_CYCLES = 1048576
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] key_code,
  output logic       key_evt,
  output logic [3:0] evt_code
);

  localparam int unsigned CW = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;

  logic [3:0]  key_q;
  qual_state_t state_q, state_d;
  logic [CW-1:0] rel_cnt_q, rel_cnt_d;

  // Two identical consecutive non-idle samples qualify a press.
  assign key_evt  = (state_q == ARMED) && (key_code != KEY_NONE) && (key_code == key_q);
  assign evt_code = key_code;

  always_comb begin
    state_d   = state_q;
    rel_cnt_d = rel_cnt_q;
    unique case (state_q)
      ARMED: begin
        rel_cnt_d = '0;
        if (key_evt) state_d = WAIT_RELEASE;
      end
      WAIT_RELEASE: begin
        // Scanner drops out to F between column scans, so only a long F run is a release.
        if (key_code != KEY_NONE) begin
          rel_cnt_d = '0;
        end else if (rel_cnt_q == CW'(RELEASE_CYCLES - 1)) begin
          rel_cnt_d = '0;
          state_d   = ARMED;
        end else begin
          rel_cnt_d = rel_cnt_q + 1'b1;
        end
      end
      default: state_d = ARMED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      key_q     <= KEY_NONE;
      state_q   <= ARMED;
      rel_cnt_q <= '0;
    end else begin
      key_q     <= key_code;
      state_q   <= state_d;
      rel_cnt_q <= rel_cnt_d;
    end
  end

endmodule

// File: rtl/keypad_operand_entry.sv
// Builds two decimal operands from keypad digits and computes their sum on '#'.
// Ports:
//   clk, reset     system clock, synchronous active-high reset
//   key_code       scanner key code: 0-9 digits, A add, D clear, E equals, F none
//   operand_a/b    operand registers
//   result         registered operand_a+operand_b (W+1 bits)
//   result_valid   one-cycle pulse when result updates
//   display_value  operand_a in S_A, operand_b in S_B, result in S_DONE
//   entry_state    current entry FSM state
// Build option: define KEYPAD_SUB_EN to let key B in S_A select subtraction
// (two's complement W+1-bit result); otherwise B is ignored.
module keypad_operand_entry
  import keypad_pkg::*;
#(
  parameter int unsigned DIGITS         = 3,
  parameter int unsigned W              = 10,
  parameter int unsigned RELEASE_CYCLES = 1048576
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [3:0]   key_code,
  output logic [W-1:0] operand_a,
  output logic [W-1:0] operand_b,
  output logic [W:0]   result,
  output logic         result_valid,
  output logic [W:0]   display_value,
  output logic [1:0]   entry_state
);

  localparam int unsigned CNT_W = $clog2(DIGITS + 1);

  logic       key_evt;
  logic [3:0] evt_code;

  key_event #(
    .RELEASE_CYCLES(RELEASE_CYCLES)
  ) u_key_event (
    .clk     (clk),
    .reset   (reset),
    .key_code(key_code),
    .key_evt (key_evt),
    .evt_code(evt_code)
  );

  entry_state_t state_q, state_d;
  logic [W-1:0] a_q, a_d, b_q, b_d;
  logic [CNT_W-1:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
  logic [W:0]   res_q, res_d, disp_q, disp_d;
  logic         rv_q, rv_d;
`ifdef KEYPAD_SUB_EN
  logic         op_q, op_d;  // 1 = subtract
`endif

  // Digit-count limit guarantees the product fits in W bits.
  function automatic logic [W-1:0] append_digit(input logic [W-1:0] v, input logic [3:0] d);
    return v * W'(10) + W'(d);
  endfunction

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    res_d   = res_q;
    rv_d    = 1'b0;
`ifdef KEYPAD_SUB_EN
    op_d    = op_q;
`endif
    if (key_evt) begin
      if (evt_code < 4'd10) begin
        unique case (state_q)
          S_A: begin
            if (cnt_a_q < CNT_W'(DIGITS)) begin
              a_d     = append_digit(a_q, evt_code);
              cnt_a_d = cnt_a_q + 1'b1;
            end
          end
          S_B: begin
            if (cnt_b_q < CNT_W'(DIGITS)) begin
              b_d     = append_digit(b_q, evt_code);
              cnt_b_d = cnt_b_q + 1'b1;
            end
          end
          default: begin
            // New entry starts directly with this digit.
            a_d     = W'(evt_code);
            cnt_a_d = CNT_W'(1);
            b_d     = '0;
            cnt_b_d = '0;
            res_d   = '0;
            state_d = S_A;
`ifdef KEYPAD_SUB_EN
            op_d    = 1'b0;
`endif
          end
        endcase
      end else begin
        case (evt_code)
          KEY_ADD: begin
            if (state_q == S_A) begin
              state_d = S_B;
              b_d     = '0;
              cnt_b_d = '0;
`ifdef KEYPAD_SUB_EN
              op_d    = 1'b0;
`endif
            end
          end
`ifdef KEYPAD_SUB_EN
          KEY_SUB: begin
            if (state_q == S_A) begin
              state_d = S_B;
              b_d     = '0;
              cnt_b_d = '0;
              op_d    = 1'b1;
            end
          end
`endif
          KEY_EQ: begin
            if (state_q == S_B) begin
`ifdef KEYPAD_SUB_EN
              res_d = op_q ? ({1'b0, a_q} - {1'b0, b_q}) : ({1'b0, a_q} + {1'b0, b_q});
`else
              res_d = {1'b0, a_q} + {1'b0, b_q};
`endif
              rv_d    = 1'b1;
              state_d = S_DONE;
            end
          end
          KEY_CLR: begin
            a_d     = '0;
            b_d     = '0;
            cnt_a_d = '0;
            cnt_b_d = '0;
            res_d   = '0;
            state_d = S_A;
`ifdef KEYPAD_SUB_EN
            op_d    = 1'b0;
`endif
          end
          default: ;
        endcase
      end
    end

    unique case (state_d)
      S_A:     disp_d = {1'b0, a_d};
      S_B:     disp_d = {1'b0, b_d};
      default: disp_d = res_d;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_A;
      a_q     <= '0;
      b_q     <= '0;
      cnt_a_q <= '0;
      cnt_b_q <= '0;
      res_q   <= '0;
      rv_q    <= 1'b0;
      disp_q  <= '0;
`ifdef KEYPAD_SUB_EN
      op_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
      res_q   <= res_d;
      rv_q    <= rv_d;
      disp_q  <= disp_d;
`ifdef KEYPAD_SUB_EN
      op_q    <= op_d;
`endif
    end
  end

  assign operand_a     = a_q;
  assign operand_b     = b_q;
  assign result        = res_q;
  assign result_valid  = rv_q;
  assign display_value = disp_q;
  assign entry_state   = state_q;

endmodule

// File: tb/tb_keypad_operand_entry.sv
// Directed self-checking bench for keypad_operand_entry with RELEASE_CYCLES=4.
module tb_keypad_operand_entry;

  localparam int unsigned W = 10;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   key_code;
  logic [W-1:0] operand_a, operand_b;
  logic [W:0]   result, display_value;
  logic         result_valid;
  logic [1:0]   entry_state;

  int n_checks = 0;
  int n_pass   = 0;
  int rv_pulses = 0;
  int rv_mark;

  always #5 clk = ~clk;

  keypad_operand_entry #(
    .DIGITS        (3),
    .W             (W),
    .RELEASE_CYCLES(4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .key_code     (key_code),
    .operand_a    (operand_a),
    .operand_b    (operand_b),
    .result       (result),
    .result_valid (result_valid),
    .display_value(display_value),
    .entry_state  (entry_state)
  );

  // Counts result_valid high samples, one sample per cycle.
  always @(negedge clk) if (result_valid) rv_pulses++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Drive a code for n cycles; returns 1 time unit after the last edge.
  task automatic drive(input logic [3:0] code, input int n);
    for (int i = 0; i < n; i++) begin
      key_code = code;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic [3:0] code);
    drive(code, 3);
    drive(4'hF, 5);
  endtask

  initial begin
    reset    = 1'b1;
    key_code = 4'hF;
    drive(4'hF, 2);
    check("rst_a", operand_a, 0);
    check("rst_state", entry_state, 0);
    reset = 1'b0;

    // Reset in the middle of entry
    press(4'h1);
    press(4'h2);
    check("mid_a12", operand_a, 12);
    check("mid_disp12", display_value, 12);
    reset = 1'b1;
    drive(4'hF, 1);
    reset = 1'b0;
    check("rst2_a", operand_a, 0);
    check("rst2_b", operand_b, 0);
    check("rst2_res", result, 0);
    check("rst2_rv", result_valid, 0);
    check("rst2_disp", display_value, 0);
    check("rst2_state", entry_state, 0);

    // 123 + 45
    rv_mark = rv_pulses;
    press(4'h1);
    press(4'h2);
    press(4'h3);
    check("add_a", operand_a, 123);
    check("add_disp_a", display_value, 123);
    press(4'hA);
    check("add_state_b", entry_state, 1);
    check("add_disp_b0", display_value, 0);
    press(4'h4);
    press(4'h5);
    check("add_b", operand_b, 45);
    check("add_disp_b", display_value, 45);
    check("add_no_rv_yet", rv_pulses - rv_mark, 0);
    press(4'hE);
    check("add_res", result, 168);
    check("add_disp_res", display_value, 168);
    check("add_state_done", entry_state, 2);
    check("add_rv_once", rv_pulses - rv_mark, 1);

    // E and A in S_DONE ignored
    rv_mark = rv_pulses;
    press(4'hE);
    press(4'hA);
    check("done_ignore_rv", rv_pulses - rv_mark, 0);
    check("done_ignore_state", entry_state, 2);
    check("done_ignore_res", result, 168);

    // Held 7 with single-cycle F gaps: one event; restarts entry from S_DONE
    for (int i = 0; i < 20; i++) drive((i % 3 == 2) ? 4'hF : 4'h7, 1);
    drive(4'hF, 5);
    check("bounce_a", operand_a, 7);
    check("bounce_state", entry_state, 0);
    check("bounce_res_clr", result, 0);
    check("bounce_b_clr", operand_b, 0);

    // Digit limit
    press(4'hD);
    for (int i = 0; i < 4; i++) press(4'h9);
    check("lim_999", operand_a, 999);

    // Leading zeros count as digits
    press(4'hD);
    press(4'h0);
    press(4'h0);
    press(4'h5);
    press(4'h6);
    check("lead_zero", operand_a, 5);

    // A with no digits gives operand_a = 0
    press(4'hD);
    press(4'hA);
    press(4'h7);
    press(4'hE);
    check("empty_a_res", result, 7);

    // Clear mid-entry, then E is ignored
    press(4'h5);
    press(4'hA);
    press(4'h3);
    press(4'hD);
    check("clr_a", operand_a, 0);
    check("clr_b", operand_b, 0);
    check("clr_res", result, 0);
    check("clr_state", entry_state, 0);
    rv_mark = rv_pulses;
    press(4'hE);
    check("clr_e_no_rv", rv_pulses - rv_mark, 0);
    check("clr_e_state", entry_state, 0);

    // Key B behaviour
    rv_mark = rv_pulses;
    press(4'h3);
    press(4'hB);
    press(4'h5);
    press(4'hE);
`ifdef KEYPAD_SUB_EN
    check("sub_res", result, 11'h7FE);
    check("sub_rv", rv_pulses - rv_mark, 1);
    check("sub_state", entry_state, 2);
`else
    check("b_ign_a", operand_a, 35);
    check("b_ign_rv", rv_pulses - rv_mark, 0);
    check("b_ign_state", entry_state, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
